// File: rtl/pl_seq_pkg.sv
// ============================================================================
// pl_seq_pkg : shared types and helpers for the pseudo_linear train sequencer
// Revision   : 1.0
// ============================================================================
`default_nettype none

package pl_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TRAIN = 3'd1,
    GAP   = 3'd2,
    TEST  = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_TRAIN = 2'd1,
    PH_TEST  = 2'd2,
    PH_DONE  = 2'd3
  } phase_t;

  localparam int unsigned SAT_MAX_W = 32;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int unsigned          w);
    logic [SAT_MAX_W-1:0] max_v;
    if (w >= SAT_MAX_W) max_v = {SAT_MAX_W{1'b1}};
    else                max_v = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
    return (v == max_v) ? v : v + SAT_MAX_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pl_label_dly.sv
// ============================================================================
// pl_label_dly : LAT-stage {valid, label} shift register aligning labels
//                with the learner's result. Revision 1.0
// ============================================================================
`default_nettype none

module pl_label_dly #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in_valid,
  input  logic in_label,
  output logic out_valid,
  output logic out_label
);

  logic [LAT-1:0] r_vld;
  logic [LAT-1:0] r_lbl;

  generate
    if (LAT == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= '0;
          r_lbl <= '0;
        end else if (clr) begin
          r_vld <= '0;
          r_lbl <= '0;
        end else begin
          r_vld <= in_valid;
          r_lbl <= in_label;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= '0;
          r_lbl <= '0;
        end else if (clr) begin
          r_vld <= '0;
          r_lbl <= '0;
        end else begin
          r_vld <= {r_vld[LAT-2:0], in_valid};
          r_lbl <= {r_lbl[LAT-2:0], in_label};
        end
      end
    end
  endgenerate

  assign out_valid = r_vld[LAT-1];
  assign out_label = r_lbl[LAT-1];

endmodule

`default_nettype wire

// File: rtl/pl_train_sequencer.sv
// ============================================================================
// pl_train_sequencer : one train pass then one scored test pass for pseudo_linear.
// Option PL_SEQ_CONFUSION_EN adds tp/fp/fn/tn counters. Revision 1.0
// ============================================================================
`default_nettype none

module pl_train_sequencer
  import pl_seq_pkg::*;
#(
  parameter int IDX_W      = 14,
  parameter int N_TRAIN    = 12665,
  parameter int N_TEST     = 2115,
  parameter int RESULT_LAT = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             smp_valid,
  input  logic             smp_label,
  output logic             smp_ready,
  output logic [IDX_W-1:0] pl_x,
  output logic             pl_y,
  output logic             pl_train_en,
  input  logic             pl_result,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] test_cnt
`ifdef PL_SEQ_CONFUSION_EN
  ,
  output logic [CNT_W-1:0] tp_cnt,
  output logic [CNT_W-1:0] fp_cnt,
  output logic [CNT_W-1:0] fn_cnt,
  output logic [CNT_W-1:0] tn_cnt
`endif
);

  localparam int N_MAX0 = (N_TRAIN > N_TEST) ? N_TRAIN : N_TEST;
  localparam int N_MAX  = (N_MAX0 > RESULT_LAT) ? N_MAX0 : RESULT_LAT;
  localparam int SMP_W  = $clog2(N_MAX + 1);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [SMP_W-1:0] r_smp_cnt;
  logic             w_hs;
  logic             w_start_go;
  logic             w_abort_go;
  logic             w_last_train;
  logic             w_last_test;
  logic             w_flush_end;
  logic             w_dly_valid;
  logic             w_dly_label;
  logic             w_hit;

  assign w_hs         = smp_valid & smp_ready;
  assign w_abort_go   = abort & (r_state != IDLE);
  assign w_start_go   = start & ~abort & ((r_state == IDLE) | (r_state == DONE));
  assign w_last_train = (r_smp_cnt == SMP_W'(N_TRAIN - 1));
  assign w_last_test  = (r_smp_cnt == SMP_W'(N_TEST - 1));
  assign w_flush_end  = (r_smp_cnt == SMP_W'(RESULT_LAT - 1));
  assign w_hit        = (pl_result == w_dly_label);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort_go) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (start)                 w_next = TRAIN;
        TRAIN:      if (w_hs && w_last_train)  w_next = GAP;
        GAP:                                   w_next = TEST;
        TEST:       if (w_hs && w_last_test)   w_next = FLUSH;
        FLUSH:      if (w_flush_end)           w_next = DONE;
        default:                               w_next = IDLE;
      endcase
    end
  end

  // Ready drops with abort so no sample is consumed by a cancelled run.
  always_comb begin
    smp_ready = 1'b0;
    phase     = PH_IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      TRAIN: begin
        smp_ready = ~abort;
        phase     = PH_TRAIN;
        busy      = 1'b1;
      end
      GAP: begin
        phase = PH_TRAIN;
        busy  = 1'b1;
      end
      TEST: begin
        smp_ready = ~abort;
        phase     = PH_TEST;
        busy      = 1'b1;
      end
      FLUSH: begin
        phase = PH_TEST;
        busy  = 1'b1;
      end
      DONE: begin
        phase = PH_DONE;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  pl_label_dly #(
    .LAT (RESULT_LAT)
  ) u_label_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_start_go | w_abort_go),
    .in_valid  (w_hs & (r_state == TEST)),
    .in_label  (smp_label),
    .out_valid (w_dly_valid),
    .out_label (w_dly_label)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_smp_cnt   <= '0;
      pl_x        <= '0;
      pl_y        <= 1'b0;
      pl_train_en <= 1'b0;
      correct_cnt <= '0;
      test_cnt    <= '0;
`ifdef PL_SEQ_CONFUSION_EN
      tp_cnt      <= '0;
      fp_cnt      <= '0;
      fn_cnt      <= '0;
      tn_cnt      <= '0;
`endif
    end else begin
      pl_train_en <= 1'b0;
      if (w_start_go) begin
        r_idx       <= '0;
        r_smp_cnt   <= '0;
        correct_cnt <= '0;
        test_cnt    <= '0;
`ifdef PL_SEQ_CONFUSION_EN
        tp_cnt      <= '0;
        fp_cnt      <= '0;
        fn_cnt      <= '0;
        tn_cnt      <= '0;
`endif
      end else if (!w_abort_go) begin
        case (r_state)
          TRAIN: if (w_hs) begin
            pl_x        <= r_idx;
            pl_y        <= smp_label;
            pl_train_en <= 1'b1;
            r_idx       <= r_idx + IDX_W'(1);
            r_smp_cnt   <= w_last_train ? '0 : r_smp_cnt + SMP_W'(1);
          end
          GAP: begin
            r_idx     <= '0;
            r_smp_cnt <= '0;
          end
          TEST: if (w_hs) begin
            pl_x      <= r_idx;
            pl_y      <= smp_label;
            r_idx     <= r_idx + IDX_W'(1);
            r_smp_cnt <= w_last_test ? '0 : r_smp_cnt + SMP_W'(1);
          end
          FLUSH: r_smp_cnt <= r_smp_cnt + SMP_W'(1);
          default: ;
        endcase

        // Score the result against the label that was presented RESULT_LAT cycles ago.
        if (w_dly_valid) begin
          test_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(test_cnt), CNT_W));
          if (w_hit) correct_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(correct_cnt), CNT_W));
`ifdef PL_SEQ_CONFUSION_EN
          case ({pl_result, w_dly_label})
            2'b11:   tp_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(tp_cnt), CNT_W));
            2'b10:   fp_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(fp_cnt), CNT_W));
            2'b01:   fn_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(fn_cnt), CNT_W));
            default: tn_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(tn_cnt), CNT_W));
          endcase
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire
